// File: rtl/keyed_dup_seq_fsm.sv
// keyed_dup_seq_fsm: key-locked stage sequencer with genuine/decoy copies of every stage
// Ports: clk, rst (async, active-high); start (IDLE only) and adv (stage states only)
// step the sequence; key picks the genuine or decoy copy of the stage being entered;
// y is x rotated by stage index (inverted in decoy stages once corrupt); busy, done,
// in_decoy report the state; decoy_cnt counts decoy entries (saturating); corrupt
// flags decoy_cnt >= CORRUPT_AFTER.
module keyed_dup_seq_fsm #(
   parameter int KEY_W = 4,
   parameter logic [KEY_W-1:0] KEY_VAL = 4'b1010,
   parameter int DATA_W = 8,
   parameter int CORRUPT_AFTER = 5,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              adv,
   input  logic [KEY_W-1:0]  key,
   input  logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] y,
   output logic              busy,
   output logic              done,
   output logic              in_decoy,
   output logic [CNT_W-1:0]  decoy_cnt,
   output logic              corrupt
);
   localparam int IW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
   localparam logic [IW-1:0] LAST = IW'(KEY_W - 1);
   localparam logic [1:0] P_IDLE = 2'd0, P_STG = 2'd1, P_DONE = 2'd2;
   logic [1:0] ph_q, ph_d;
   logic [IW-1:0] idx_q, idx_d;
   logic dec_q, dec_d, ent;
   logic [2*DATA_W-1:0] dbl;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph_q <= P_IDLE;
         idx_q <= '0;
         dec_q <= 1'b0;
         decoy_cnt <= '0;
      end else begin
         ph_q <= ph_d;
         idx_q <= idx_d;
         dec_q <= dec_d;
         if (ent && dec_d && decoy_cnt != '1)
            decoy_cnt <= decoy_cnt + 1'b1;
      end
   end
   // ent marks an edge that enters a stage; the key bit of that stage picks the copy
   always_comb begin
      ph_d = ph_q;
      idx_d = idx_q;
      dec_d = dec_q;
      ent = 1'b0;
      case (ph_q)
         P_IDLE: begin
            idx_d = '0;
            dec_d = 1'b0;
            if (start) begin
               ph_d = P_STG;
               ent = 1'b1;
            end
         end
         P_STG: begin
            if (idx_q > LAST) begin
               ph_d = P_IDLE;
               idx_d = '0;
               dec_d = 1'b0;
            end else if (adv && idx_q == LAST) begin
               ph_d = P_DONE;
               idx_d = '0;
               dec_d = 1'b0;
            end else if (adv) begin
               idx_d = idx_q + 1'b1;
               ent = 1'b1;
            end
         end
         default: begin
            ph_d = P_IDLE;
            idx_d = '0;
            dec_d = 1'b0;
         end
      endcase
      if (ent)
         dec_d = key[idx_d] != KEY_VAL[idx_d];
   end
   // rotate-left via a doubled word: the upper half of {x,x}<<s is x rotated by s
   always_comb begin
      dbl = {x, x} << (int'(idx_q) % DATA_W);
      busy = ph_q == P_STG;
      in_decoy = busy & dec_q;
      done = ph_q == P_DONE;
      corrupt = int'(decoy_cnt) >= CORRUPT_AFTER;
      y = busy ? dbl[2*DATA_W-1 -: DATA_W] ^ {DATA_W{in_decoy & corrupt}} : '0;
   end
endmodule

// File: tb/tb_keyed_dup_seq_fsm.sv
// tb_keyed_dup_seq_fsm: randomized run sequences checked against a stage-level reference model
module tb_keyed_dup_seq_fsm;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, adv = 1'b0;
   logic [3:0] key = 4'b0;
   logic [7:0] x = 8'h0;
   logic [7:0] y_a, y_b, cnt_a;
   logic [2:0] cnt_b;
   logic busy_a, done_a, dec_a, cor_a, busy_b, done_b, dec_b, cor_b;
   logic [3:0] kv = 4'b1010;
   int total = 0, bad = 0;
   int m_ph = 0, m_idx = 0, m_cnt = 0;
   bit m_dec = 1'b0;
   always #5 clk = ~clk;
   keyed_dup_seq_fsm dut_a (.clk(clk), .rst(rst), .start(start), .adv(adv), .key(key), .x(x),
      .y(y_a), .busy(busy_a), .done(done_a), .in_decoy(dec_a), .decoy_cnt(cnt_a), .corrupt(cor_a));
   keyed_dup_seq_fsm #(.CNT_W(3)) dut_b (.clk(clk), .rst(rst), .start(start), .adv(adv), .key(key), .x(x),
      .y(y_b), .busy(busy_b), .done(done_b), .in_decoy(dec_b), .decoy_cnt(cnt_b), .corrupt(cor_b));
   function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
      logic [7:0] r = 8'h0;
      for (int b = 0; b < 8; b++) r[(b + s) % 8] = v[b];
      return r;
   endfunction
   function automatic int cap(input int cmax);
      return (m_cnt < cmax) ? m_cnt : cmax;
   endfunction
   function automatic logic [7:0] exp_y(input int c);
      if (m_ph != 1) return 8'h00;
      return rotl(x, m_idx % 8) ^ ((m_dec && c >= 5) ? 8'hff : 8'h00);
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic check_all();
      chk("y_a", 32'(y_a), 32'(exp_y(cap(255))));
      chk("busy_a", 32'(busy_a), 32'(m_ph == 1));
      chk("done_a", 32'(done_a), 32'(m_ph == 2));
      chk("in_decoy_a", 32'(dec_a), 32'(m_ph == 1 && m_dec));
      chk("cnt_a", 32'(cnt_a), 32'(cap(255)));
      chk("corrupt_a", 32'(cor_a), 32'(cap(255) >= 5));
      chk("y_b", 32'(y_b), 32'(exp_y(cap(7))));
      chk("busy_b", 32'(busy_b), 32'(m_ph == 1));
      chk("in_decoy_b", 32'(dec_b), 32'(m_ph == 1 && m_dec));
      chk("cnt_b", 32'(cnt_b), 32'(cap(7)));
      chk("corrupt_b", 32'(cor_b), 32'(cap(7) >= 5));
   endtask
   task automatic enter(input int i);
      m_ph = 1;
      m_idx = i;
      m_dec = key[i] != kv[i];
      if (m_dec) m_cnt++;
   endtask
   task automatic step();
      if (m_ph == 0) begin
         if (start) enter(0);
      end else if (m_ph == 1) begin
         if (adv) begin
            if (m_idx == 3) m_ph = 2;
            else enter(m_idx + 1);
         end
      end else m_ph = 0;
      @(posedge clk);
      #1;
      check_all();
   endtask
   task automatic run(input logic [3:0] k, input bit rnd_x, input int max_hold, input int stages);
      start = 1'b1;
      adv = 1'b0;
      key = k;
      x = rnd_x ? 8'($urandom) : 8'h81;
      step();
      for (int i = 0; i < stages; i++) begin
         repeat ($urandom_range(max_hold)) begin
            adv = 1'b0;
            start = 1'($urandom);
            key = 4'($urandom);
            if (rnd_x) x = 8'($urandom);
            step();
         end
         if (i == stages - 1 && stages < 4) break;
         adv = 1'b1;
         start = 1'($urandom);
         key = (i < 3) ? k : 4'($urandom);
         if (rnd_x) x = 8'($urandom);
         step();
      end
      adv = 1'b0;
      start = 1'b0;
      if (stages < 4) return;
      step();
      adv = 1'($urandom);
      step();
      adv = 1'b0;
   endtask
   task automatic async_reset();
      #3 rst = 1'b1;
      m_ph = 0;
      m_cnt = 0;
      m_dec = 1'b0;
      #1 check_all();
      #1 rst = 1'b0;
   endtask
   initial begin
      #2 check_all();
      #5 rst = 1'b0;
      run(4'b1010, 1'b0, 0, 4);
      run(4'b1010, 1'b1, 2, 4);
      run(4'b1011, 1'b0, 1, 4);
      repeat (4) run(4'b1011, 1'b0, 1, 4);
      chk("cnt_after_5_decoy_runs", 32'(cnt_a), 32'd5);
      async_reset();
      run(4'b0101, 1'b0, 1, 4);
      chk("cnt_after_all_decoy_run", 32'(cnt_a), 32'd4);
      run(4'b0101, 1'b0, 1, 4);
      run(4'b0101, 1'b1, 1, 4);
      chk("cnt_b_saturated", 32'(cnt_b), 32'd7);
      chk("cnt_a_no_sat", 32'(cnt_a), 32'd12);
      async_reset();
      run(4'b0101, 1'b0, 1, 3);
      chk("mid_run_cnt", 32'(cnt_a), 32'd3);
      async_reset();
      run(4'b1010, 1'b0, 1, 4);
      repeat (25) run(4'($urandom), 1'b1, 2, 4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
